nibble_serial_sub: RTL and testbench
====================================

// Module: nibble_serial_sub
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor (diff = a - b), one 4-bit lookahead slice per clock.
//  Operates as a two's-complement adder: a + ~b + 1. The slice is reused over WIDTH/4 cycles,
//  least significant nibble first.
//  Sits in the datapath as the area-cheap subtract unit, with valid/ready on both sides.
//  Also reports borrow, zero and signed overflow.
// PARAMETERS
//  WIDTH  16  operand/result width; multiple of 4, >= 8; N = WIDTH/4 nibble steps
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a/b valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      result valid, held until accepted
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b mod 2^WIDTH
//  borrow     out  1      1 when unsigned a < b
//  zero       out  1      1 when diff == 0
//  overflow   out  1      signed overflow of a - b
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, nibble counter=0, carry=1.
//   - out_valid=0; diff, borrow, zero and overflow all 0.
//   - in_ready=0 while rst is high.
//  FSM states:
//   - IDLE: in_ready=1. in_valid&in_ready at an edge latches a/b, clears diff, sets carry=1
//     and counter=0, then goes to RUN.
//   - RUN: in_ready=0. Edge k (k=0..N-1) computes {c,s} = a[4k+3:4k] + ~b[4k+3:4k] + carry.
//     Carry uses lookahead: g=x&y, p=x|y, c1..c4 in closed form. s = x^y^c.
//     s is written to diff[4k+3:4k], carry<=c4, counter++. Edge k=N-1 goes to DONE.
//   - DONE: out_valid=1, in_ready=0; outputs stable. out_valid&out_ready at an edge goes to
//     IDLE, out_valid<=0.
//  Flags (registered, valid from the cycle out_valid rises):
//   - borrow = ~final carry
//   - zero = (diff==0)
//   - overflow = (a[W-1]!=b[W-1]) & (diff[W-1]!=a[W-1])
//  Latency and throughput:
//   - out_valid rises N edges after the accepting edge.
//   - Minimum issue interval is N+2 cycles (accept, N steps, drain edge).
//   - WIDTH=16: 4-edge latency.
//  Handshake:
//   - in_valid is ignored outside IDLE; a/b may change freely after acceptance.
//   - out_valid never drops without out_ready.
//   - No bypass: a new operand cannot be accepted on the same edge as the result drain.
//  diff mid-RUN holds partial nibbles; it is don't-care while out_valid=0.
//  Wrap-around: diff is modulo 2^WIDTH; carry out of the top nibble feeds borrow only.
//  Reset mid-RUN/DONE: aborts immediately, and the result is discarded.
// TESTING
//  1. a=0x1234, b=0x0234, accept at edge E
//     -> out_valid at E+4; diff=0x1000, borrow=0, zero=0, overflow=0.
//  2. a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, zero=0, overflow=0.
//  3. a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, overflow=1.
//     a=0x7FFF, b=0xFFFF -> diff=0x8000, borrow=1, overflow=1.
//  4. a=0x5A5A, b=0x5A5A -> diff=0x0000, zero=1, borrow=0.
//     a=0xFFFF, b=0x0000 -> diff=0xFFFF.
//  5. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new a/b.
//     -> result and flags stable, in_ready=0.
//     Raise out_ready -> IDLE, then the pending op is accepted and its result is correct.
//  6. Assert rst after 2 RUN edges -> out_valid=0 and in_ready=0 at once; IDLE after release.
//     Next op 0x0100-0x0001 -> 0x00FF.
//  Bench also runs 1000 random ops against a - b with random out_ready stalls, for WIDTH=16
//  and WIDTH=32.

Source files
------------

// File: rtl/nibble_serial_sub.sv
// Serial WIDTH-bit subtractor: one 4-bit lookahead slice per clock.
// Computes a + ~b + 1, least significant nibble first, with flags.
module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [3:0]       x;
  logic [3:0]       y;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       s;
  logic [4:0]       c;
  logic [WIDTH-1:0] diff_n;
  logic             last;

  // Next state and handshake outputs
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One nibble of a + ~b + carry with closed-form lookahead carries
  always_comb begin
    last = (cnt == LAST);
    x    = a_r[int'(cnt)*4 +: 4];
    y    = ~b_r[int'(cnt)*4 +: 4];
    g    = x & y;
    p    = x | y;
    c[0] = carry;
    c[1] = g[0] | (p[0] & carry);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & carry);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    s    = x ^ y ^ c[3:0];
    diff_n = diff;
    diff_n[int'(cnt)*4 +: 4] = s;
  end

  // State, operand, partial result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b1;
      a_r      <= '0;
      b_r      <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            diff  <= '0;
            carry <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          diff  <= diff_n;
          carry <= c[4];
          cnt   <= cnt + 1'b1;
          if (last) begin
            borrow   <= ~c[4];
            zero     <= (diff_n == '0);
            overflow <= (a_r[WIDTH-1] != b_r[WIDTH-1])
                      & (diff_n[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub at WIDTH=16 and WIDTH=32.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_nibble_serial_sub;

  typedef struct packed {
    logic [31:0] d;
    logic        bw;
    logic        z;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, diff16;
  logic        borrow16, zero16, ovf16;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, diff32;
  logic        borrow32, zero32, ovf32;

  exp_t q16[$];
  exp_t q32[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stall_en = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_sub #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16),
    .diff(diff16), .borrow(borrow16),
    .zero(zero16), .overflow(ovf16)
  );

  nibble_serial_sub #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32),
    .diff(diff32), .borrow(borrow32),
    .zero(zero32), .overflow(ovf32)
  );

  function automatic exp_t mk(logic [31:0] d, logic bw,
                              logic z, logic ov);
    exp_t e;
    e.d  = d;
    e.bw = bw;
    e.z  = z;
    e.ov = ov;
    return e;
  endfunction

  // Reference model built from signed/unsigned integer arithmetic
  function automatic exp_t model(int w, logic [31:0] a,
                                 logic [31:0] b);
    exp_t        e;
    logic [31:0] m;
    longint      sa, sb, d, hi;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a  = a & m;
    b  = b & m;
    sa = a[w-1] ? longint'(a) - (64'sd1 <<< w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (64'sd1 <<< w) : longint'(b);
    hi = (64'sd1 <<< (w - 1)) - 1;
    d  = sa - sb;
    e.d  = (a - b) & m;
    e.bw = (a < b);
    e.z  = (e.d == 32'h0);
    e.ov = (d > hi) || (d < -hi - 1);
    return e;
  endfunction

  function automatic exp_t out16();
    return mk({16'h0, diff16}, borrow16, zero16, ovf16);
  endfunction

  function automatic exp_t out32();
    return mk(diff32, borrow32, zero32, ovf32);
  endfunction

  task automatic chk(string n, exp_t g, exp_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got d=%h bw=%b z=%b ov=%b want d=%h bw=%b z=%b ov=%b",
               n, g.d, g.bw, g.z, g.ov, e.d, e.bw, e.z, e.ov);
    end
  endtask

  task automatic chkb(string n, logic g, logic e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got %b want %b", n, g, e);
    end
  endtask

  task automatic chki(string n, int g, int e);
    checks++;
    if (g != e) begin
      failures++;
      $display("FAIL %s got %0d want %0d", n, g, e);
    end
  endtask

  // Drive one operand pair, push its expectation when the handshake is seen
  task automatic issue(int w, logic [31:0] a, logic [31:0] b,
                       exp_t e);
    int n   = 0;
    bit got = 1'b0;
    @(posedge clk);
    #1;
    if (w == 16) begin
      a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1;
    end else begin
      a32 = a; b32 = b; iv32 = 1'b1;
    end
    while (!got && n < 400) begin
      @(negedge clk);
      if (w == 16 && ir16 && iv16) begin
        got = 1'b1;
        q16.push_back(e);
      end else if (w == 32 && ir32 && iv32) begin
        got = 1'b1;
        q32.push_back(e);
      end
      n++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout w=%0d got 0 want 1", w);
    end
    @(posedge clk);
    #1;
    if (w == 16) begin
      iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    end else begin
      iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q32.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q16.size() != 0 || q32.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got %0d/%0d pending want 0/0",
               q16.size(), q32.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each accepted result against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (ov16 && or16) begin
        if (q16.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected16 got d=%h want none", diff16);
        end else begin
          chk("result16", out16(), q16.pop_front());
        end
      end
      if (ov32 && or32) begin
        if (q32.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected32 got d=%h want none", diff32);
        end else begin
          chk("result32", out32(), q32.pop_front());
        end
      end
    end
  end

  // Random consumer stalls
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        or16 = ($urandom_range(0, 3) != 0);
        or32 = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [31:0] ra, rb;
    rst  = 1'b1;
    iv16 = 1'b0; iv32 = 1'b0;
    or16 = 1'b1; or32 = 1'b1;
    a16  = '0; b16 = '0; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset16", out16(), mk(32'h0, 1'b0, 1'b0, 1'b0));
    chk("reset32", out32(), mk(32'h0, 1'b0, 1'b0, 1'b0));
    chkb("reset_ov16", ov16, 1'b0);
    chkb("reset_ir16", ir16, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chkb("idle_ir16", ir16, 1'b1);

    issue(16, 32'h1234, 32'h0234, mk(32'h1000, 0, 0, 0));
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chki("latency16", lat, 4);
    drain();

    issue(16, 32'h0000, 32'h0001, mk(32'hFFFF, 1, 0, 0));
    issue(16, 32'h8000, 32'h0001, mk(32'h7FFF, 0, 0, 1));
    issue(16, 32'h7FFF, 32'hFFFF, mk(32'h8000, 1, 0, 1));
    issue(16, 32'h5A5A, 32'h5A5A, mk(32'h0000, 0, 1, 0));
    issue(16, 32'hFFFF, 32'h0000, mk(32'hFFFF, 0, 0, 0));
    issue(32, 32'h0000_0000, 32'h0000_0001,
          mk(32'hFFFF_FFFF, 1, 0, 0));
    issue(32, 32'h8000_0000, 32'h0000_0001,
          mk(32'h7FFF_FFFF, 0, 0, 1));
    issue(32, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
          mk(32'h0000_0000, 0, 1, 0));
    drain();

    or16 = 1'b0;
    issue(16, 32'h0003, 32'h0005, mk(32'hFFFE, 1, 0, 0));
    iv16 = 1'b1; a16 = 16'h0100; b16 = 16'h00FF;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chki("bp_latency16", lat, 4);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold16", out16(), mk(32'hFFFE, 1, 0, 0));
      chkb("bp_ir16", ir16, 1'b0);
      chkb("bp_ov16", ov16, 1'b1);
    end
    @(posedge clk);
    #1;
    or16 = 1'b1;
    issue(16, 32'h0100, 32'h00FF, mk(32'h0001, 0, 0, 0));
    drain();

    issue(16, 32'h1111, 32'h0001, mk(32'h1110, 0, 0, 0));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chkb("abort_ov16", ov16, 1'b0);
    chkb("abort_ir16", ir16, 1'b0);
    q16.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chkb("abort_idle16", ir16, 1'b1);
    issue(16, 32'h0100, 32'h0001, mk(32'h00FF, 0, 0, 0));
    drain();

    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 15) == 0) ? ra : $urandom;
      issue(16, ra & 32'hFFFF, rb & 32'hFFFF, model(16, ra, rb));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 15) == 0) ? ra : $urandom;
      issue(32, ra, rb, model(32, ra, rb));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    stall_en = 1'b0;
    @(posedge clk);
    #2;
    or16 = 1'b1;
    or32 = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
